// File: rtl/ct_biu_ar_sched.sv
// ct_biu_ar_sched
// Read-address scheduler for the BIU. IFU and LSU read requests are
// arbitrated into a single-entry AR holding register that drives the bus
// AR channel. LSU wins by default; an aging counter forces an IFU win after
// STARVE_LIMIT consecutive LSU wins over a waiting IFU. Issue is throttled so
// that the held entry plus reads in flight never exceed MAX_OSTD.

module ct_biu_ar_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_OSTD     = 8
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        ifu_ar_req,
    input  logic [39:0] ifu_ar_addr,
    input  logic        ifu_ar_id,
    input  logic [25:0] ifu_ar_attr,
    input  logic        lsu_ar_req,
    input  logic [39:0] lsu_ar_addr,
    input  logic [4:0]  lsu_ar_id,
    input  logic [25:0] lsu_ar_attr,
    input  logic        arready,
    input  logic        rd_done,
    output logic        biu_ifu_ar_grnt,
    output logic        biu_lsu_ar_grnt,
    output logic        arvalid,
    output logic [39:0] araddr,
    output logic [4:0]  arid,
    output logic [25:0] arattr,
    output logic [3:0]  ar_ostd_cnt,
    output logic        ar_idle
);

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic [4:0] MAX_OSTD_C   = 5'(MAX_OSTD);

    // Attribute layout (msb first):
    // lock[25] bar[24:23] user[22:20] domain[19:18] snoop[17:14]
    // prot[13:11] cache[10:7] burst[6:5] size[4:2] len[1:0]
    // Instruction fetches never lock, never carry barriers and never set
    // the top user bit, so those fields are scrubbed on the IFU path.
    function automatic logic [25:0] ifu_attr_scrub(input logic [25:0] attr);
        logic [25:0] res;
        res        = attr;
        res[25]    = 1'b0;
        res[24:23] = 2'b00;
        res[22]    = 1'b0;
        return res;
    endfunction

    // Registered state
    logic        arvalid_r;
    logic [39:0] araddr_r;
    logic [4:0]  arid_r;
    logic [25:0] arattr_r;
    logic [3:0]  ostd_cnt_r;
    logic [3:0]  starve_cnt_r;
    logic        ar_idle_r;

    // Combinational helpers
    logic        handshake_s;
    logic [4:0]  inflight_s;
    logic        slot_free_s;
    logic        ifu_grnt_s;
    logic        lsu_grnt_s;
    logic        rd_dec_s;
    logic        arvalid_nxt_s;
    logic [39:0] araddr_nxt_s;
    logic [4:0]  arid_nxt_s;
    logic [25:0] arattr_nxt_s;
    logic [3:0]  ostd_nxt_s;
    logic [3:0]  starve_nxt_s;
    logic        ar_idle_nxt_s;

    // Slot availability: held entry drains this cycle (or is empty) and the
    // outstanding budget, counting the held entry, still has room.
    always_comb begin
        handshake_s = arvalid_r & arready;
        inflight_s  = {1'b0, ostd_cnt_r} + {4'b0000, arvalid_r};
        if ((!arvalid_r || arready) && (inflight_s < MAX_OSTD_C)) begin
            slot_free_s = 1'b1;
        end else begin
            slot_free_s = 1'b0;
        end
    end

    // Arbitration: LSU by default, IFU when alone or when it has aged out.
    always_comb begin
        ifu_grnt_s = 1'b0;
        lsu_grnt_s = 1'b0;
        if (cpurst_b && slot_free_s) begin
            if (ifu_ar_req && (!lsu_ar_req || (starve_cnt_r == STARVE_LIM_C))) begin
                ifu_grnt_s = 1'b1;
            end else if (lsu_ar_req) begin
                lsu_grnt_s = 1'b1;
            end else begin
                ifu_grnt_s = 1'b0;
                lsu_grnt_s = 1'b0;
            end
        end else begin
            ifu_grnt_s = 1'b0;
            lsu_grnt_s = 1'b0;
        end
    end

    // Holding register next state: load on grant, clear on bare handshake.
    always_comb begin
        arvalid_nxt_s = arvalid_r;
        araddr_nxt_s  = araddr_r;
        arid_nxt_s    = arid_r;
        arattr_nxt_s  = arattr_r;
        if (ifu_grnt_s) begin
            arvalid_nxt_s = 1'b1;
            araddr_nxt_s  = ifu_ar_addr;
            arid_nxt_s    = {4'b1000, ifu_ar_id};
            arattr_nxt_s  = ifu_attr_scrub(ifu_ar_attr);
        end else if (lsu_grnt_s) begin
            arvalid_nxt_s = 1'b1;
            araddr_nxt_s  = lsu_ar_addr;
            arid_nxt_s    = lsu_ar_id;
            arattr_nxt_s  = lsu_ar_attr;
        end else if (handshake_s) begin
            arvalid_nxt_s = 1'b0;
        end else begin
            arvalid_nxt_s = arvalid_r;
        end
    end

    // Outstanding counter next state; a completion with nothing in flight
    // is ignored so the count never wraps.
    always_comb begin
        ostd_nxt_s = ostd_cnt_r;
        rd_dec_s   = rd_done & (ostd_cnt_r != 4'd0);
        case ({handshake_s, rd_dec_s})
            2'b10:   ostd_nxt_s = ostd_cnt_r + 4'd1;
            2'b01:   ostd_nxt_s = ostd_cnt_r - 4'd1;
            default: ostd_nxt_s = ostd_cnt_r;
        endcase
    end

    // Aging counter next state: counts LSU wins over a waiting IFU.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (!ifu_ar_req || ifu_grnt_s) begin
            starve_nxt_s = 4'd0;
        end else if (lsu_grnt_s) begin
            if (starve_cnt_r < STARVE_LIM_C) begin
                starve_nxt_s = starve_cnt_r + 4'd1;
            end else begin
                starve_nxt_s = starve_cnt_r;
            end
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Idle flag is registered from the next-state values so it tracks
    // arvalid/ar_ostd_cnt in the same cycle.
    always_comb begin
        ar_idle_nxt_s = 1'b0;
        if (!arvalid_nxt_s && (ostd_nxt_s == 4'd0)) begin
            ar_idle_nxt_s = 1'b1;
        end else begin
            ar_idle_nxt_s = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            arvalid_r    <= 1'b0;
            araddr_r     <= 40'd0;
            arid_r       <= 5'd0;
            arattr_r     <= 26'd0;
            ostd_cnt_r   <= 4'd0;
            starve_cnt_r <= 4'd0;
            ar_idle_r    <= 1'b1;
        end else begin
            arvalid_r    <= arvalid_nxt_s;
            araddr_r     <= araddr_nxt_s;
            arid_r       <= arid_nxt_s;
            arattr_r     <= arattr_nxt_s;
            ostd_cnt_r   <= ostd_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            ar_idle_r    <= ar_idle_nxt_s;
        end
    end

    assign biu_ifu_ar_grnt = ifu_grnt_s;
    assign biu_lsu_ar_grnt = lsu_grnt_s;
    assign arvalid         = arvalid_r;
    assign araddr          = araddr_r;
    assign arid            = arid_r;
    assign arattr          = arattr_r;
    assign ar_ostd_cnt     = ostd_cnt_r;
    assign ar_idle         = ar_idle_r;

endmodule

// File: tb/tb_ct_biu_ar_sched.sv
// Bench for ct_biu_ar_sched: two instances (MAX_OSTD 8 and 2) share the
// request inputs but have their own arready/rd_done. A rule-level model
// tracks each instance and is compared every cycle; directed checks pin
// the scenarios with hand-computed values.

module tb_ct_biu_ar_sched;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        ifu_ar_req;
    logic [39:0] ifu_ar_addr;
    logic        ifu_ar_id;
    logic [25:0] ifu_ar_attr;
    logic        lsu_ar_req;
    logic [39:0] lsu_ar_addr;
    logic [4:0]  lsu_ar_id;
    logic [25:0] lsu_ar_attr;
    logic        arready_a, rd_done_a, arready_b, rd_done_b;

    logic        a_ifu_grnt, a_lsu_grnt, a_arvalid, a_idle;
    logic [39:0] a_araddr;
    logic [4:0]  a_arid;
    logic [25:0] a_arattr;
    logic [3:0]  a_ostd;
    logic        b_ifu_grnt, b_lsu_grnt, b_arvalid, b_idle;
    logic [39:0] b_araddr;
    logic [4:0]  b_arid;
    logic [25:0] b_arattr;
    logic [3:0]  b_ostd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ct_biu_ar_sched #(.STARVE_LIMIT(STARVE), .MAX_OSTD(8)) dut_a (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b),
        .ifu_ar_req(ifu_ar_req), .ifu_ar_addr(ifu_ar_addr), .ifu_ar_id(ifu_ar_id), .ifu_ar_attr(ifu_ar_attr),
        .lsu_ar_req(lsu_ar_req), .lsu_ar_addr(lsu_ar_addr), .lsu_ar_id(lsu_ar_id), .lsu_ar_attr(lsu_ar_attr),
        .arready(arready_a), .rd_done(rd_done_a),
        .biu_ifu_ar_grnt(a_ifu_grnt), .biu_lsu_ar_grnt(a_lsu_grnt),
        .arvalid(a_arvalid), .araddr(a_araddr), .arid(a_arid), .arattr(a_arattr),
        .ar_ostd_cnt(a_ostd), .ar_idle(a_idle));

    ct_biu_ar_sched #(.STARVE_LIMIT(STARVE), .MAX_OSTD(2)) dut_b (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b),
        .ifu_ar_req(ifu_ar_req), .ifu_ar_addr(ifu_ar_addr), .ifu_ar_id(ifu_ar_id), .ifu_ar_attr(ifu_ar_attr),
        .lsu_ar_req(lsu_ar_req), .lsu_ar_addr(lsu_ar_addr), .lsu_ar_id(lsu_ar_id), .lsu_ar_attr(lsu_ar_attr),
        .arready(arready_b), .rd_done(rd_done_b),
        .biu_ifu_ar_grnt(b_ifu_grnt), .biu_lsu_ar_grnt(b_lsu_grnt),
        .arvalid(b_arvalid), .araddr(b_araddr), .arid(b_arid), .arattr(b_arattr),
        .ar_ostd_cnt(b_ostd), .ar_idle(b_idle));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [39:0] a;
        logic [4:0]  id;
        logic [25:0] at;
        int          ostd;
        int          starve;
    } mst_t;

    mst_t ma, mb;
    bit   mok = 1'b0;

    function automatic void model_step(input mst_t s, input bit rst_n, input bit rdy, input bit done,
                                       input int max_o, output bit gi, output bit gl, output mst_t n);
        int  busy;
        bit  free, hs;
        n  = s;
        gi = 1'b0;
        gl = 1'b0;
        if (!rst_n) begin
            n.v = 1'b0; n.a = '0; n.id = '0; n.at = '0; n.ostd = 0; n.starve = 0;
            return;
        end
        busy = s.ostd + (s.v ? 1 : 0);
        free = (!s.v || rdy) && (busy < max_o);
        if (free && ifu_ar_req && (!lsu_ar_req || s.starve == STARVE)) gi = 1'b1;
        else if (free && lsu_ar_req) gl = 1'b1;
        hs = s.v && rdy;
        n.ostd = s.ostd + (hs ? 1 : 0) - ((done && s.ostd > 0) ? 1 : 0);
        if (gi) begin
            n.v = 1'b1; n.a = ifu_ar_addr; n.id = {4'b1000, ifu_ar_id};
            n.at = ifu_ar_attr; n.at[25] = 1'b0; n.at[24:23] = 2'b00; n.at[22] = 1'b0;
        end else if (gl) begin
            n.v = 1'b1; n.a = lsu_ar_addr; n.id = lsu_ar_id; n.at = lsu_ar_attr;
        end else if (hs) begin
            n.v = 1'b0;
        end
        if (!ifu_ar_req || gi) n.starve = 0;
        else if (gl) n.starve = (s.starve + 1 > STARVE) ? STARVE : s.starve + 1;
    endfunction

    // Per-cycle comparison of both instances against the model.
    initial begin
        mst_t na, nb;
        bit   gia, gla, gib, glb;
        forever begin
            @(negedge clk);
            model_step(ma, cpurst_b, arready_a, rd_done_a, 8, gia, gla, na);
            model_step(mb, cpurst_b, arready_b, rd_done_b, 2, gib, glb, nb);
            if (mok) begin
                chk("a_ifu_grnt", 64'(a_ifu_grnt), 64'(gia));
                chk("a_lsu_grnt", 64'(a_lsu_grnt), 64'(gla));
                chk("a_arvalid",  64'(a_arvalid),  64'(ma.v));
                chk("a_ostd",     64'(a_ostd),     64'(ma.ostd));
                chk("a_idle",     64'(a_idle),     64'(!ma.v && ma.ostd == 0));
                if (ma.v) begin
                    chk("a_araddr", 64'(a_araddr), 64'(ma.a));
                    chk("a_arid",   64'(a_arid),   64'(ma.id));
                    chk("a_arattr", 64'(a_arattr), 64'(ma.at));
                end
                chk("b_ifu_grnt", 64'(b_ifu_grnt), 64'(gib));
                chk("b_lsu_grnt", 64'(b_lsu_grnt), 64'(glb));
                chk("b_arvalid",  64'(b_arvalid),  64'(mb.v));
                chk("b_ostd",     64'(b_ostd),     64'(mb.ostd));
                chk("b_idle",     64'(b_idle),     64'(!mb.v && mb.ostd == 0));
                if (mb.v) begin
                    chk("b_araddr", 64'(b_araddr), 64'(mb.a));
                    chk("b_arid",   64'(b_arid),   64'(mb.id));
                    chk("b_arattr", 64'(b_arattr), 64'(mb.at));
                end
            end
            ma = na;
            mb = nb;
            if (!cpurst_b) mok = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    localparam logic [39:0] A_I = 40'h12_3456_789A;
    localparam logic [39:0] A_L = 40'hAB_CDEF_0120;
    localparam logic [25:0] AT_L = 26'h3C0_1234;

    initial begin
        int exp_pat [10];
        exp_pat = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        cpurst_b    = 1'b0;
        ifu_ar_req  = 1'b1;
        ifu_ar_addr = A_I;
        ifu_ar_id   = 1'b1;
        ifu_ar_attr = 26'h3FF_FFFF;
        lsu_ar_req  = 1'b0;
        lsu_ar_addr = A_L;
        lsu_ar_id   = 5'h0B;
        lsu_ar_attr = AT_L;
        arready_a   = 1'b1;
        rd_done_a   = 1'b0;
        arready_b   = 1'b1;
        rd_done_b   = 1'b0;

        // Reset values with an IFU request pending.
        nxt(); smp();
        chk("rst_arvalid", 64'(a_arvalid), 64'd0);
        chk("rst_araddr",  64'(a_araddr),  64'd0);
        chk("rst_ostd",    64'(a_ostd),    64'd0);
        chk("rst_idle",    64'(a_idle),    64'd1);
        chk("rst_ifu_grnt", 64'(a_ifu_grnt), 64'd0);

        // Single IFU request: grant in cycle 0 after release.
        nxt(); cpurst_b = 1'b1;
        smp();
        chk("ifu_c0_grnt", 64'(a_ifu_grnt), 64'd1);
        nxt(); ifu_ar_req = 1'b0;
        smp();
        chk("ifu_c1_arvalid", 64'(a_arvalid), 64'd1);
        chk("ifu_c1_arid",    64'(a_arid),    64'h11);
        chk("ifu_c1_araddr",  64'(a_araddr),  64'(A_I));
        chk("ifu_c1_lockbar", 64'(a_arattr[25:22]), 64'd0);
        chk("ifu_c1_arattr",  64'(a_arattr), 64'h03F_FFFF);
        nxt(); smp();
        chk("ifu_c2_ostd", 64'(a_ostd), 64'd1);
        nxt(); rd_done_a = 1'b1;
        smp();
        nxt(); rd_done_a = 1'b0;
        smp();
        chk("drain_ostd", 64'(a_ostd), 64'd0);

        // Both requesters held: L,L,L,L,I repeating.
        nxt(); ifu_ar_req = 1'b1; lsu_ar_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk($sformatf("starve_pat%0d", i), 64'({a_ifu_grnt, a_lsu_grnt}), 64'(exp_pat[i]));
            if (i == 5) chk("starve_clr5", 64'(dut_a.starve_cnt_r), 64'd0);
            nxt();
            if (i == 1) rd_done_a = 1'b1;
        end
        ifu_ar_req = 1'b0; rd_done_a = 1'b0; arready_a = 1'b0;

        // Backpressure: five stalled cycles, payload stable, no grants.
        for (int i = 0; i < 5; i++) begin
            smp();
            if (i == 0) chk("starve_clr10", 64'(dut_a.starve_cnt_r), 64'd0);
            chk($sformatf("bp_arvalid%0d", i), 64'(a_arvalid), 64'd1);
            chk($sformatf("bp_araddr%0d", i),  64'(a_araddr),  64'(A_I));
            chk($sformatf("bp_grnt%0d", i), 64'({a_ifu_grnt, a_lsu_grnt}), 64'd0);
            nxt();
        end
        arready_a = 1'b1;
        smp();
        chk("bp_release_grnt", 64'(a_lsu_grnt), 64'd1);
        nxt(); smp();
        chk("b2b_araddr", 64'(a_araddr), 64'(A_L));
        chk("b2b_arid",   64'(a_arid),   64'h0B);
        chk("b2b_arattr", 64'(a_arattr), 64'(AT_L));
        chk("b2b_ostd",   64'(a_ostd),   64'd2);

        // Reset mid-operation.
        nxt(); cpurst_b = 1'b0;
        smp();
        chk("pre_rst_arvalid", 64'(a_arvalid), 64'd1);
        chk("pre_rst_ostd",    64'(a_ostd),    64'd3);
        chk("in_rst_grnt",     64'(a_lsu_grnt), 64'd0);
        nxt(); cpurst_b = 1'b1; lsu_ar_req = 1'b0; rd_done_a = 1'b1;
        smp();
        chk("post_rst_arvalid", 64'(a_arvalid), 64'd0);
        chk("post_rst_ostd",    64'(a_ostd),    64'd0);
        chk("post_rst_idle",    64'(a_idle),    64'd1);
        nxt(); rd_done_a = 1'b0;
        smp();
        chk("rd_done_at_zero", 64'(a_ostd), 64'd0);

        // MAX_OSTD = 2 instance: throttle and release.
        nxt(); lsu_ar_req = 1'b1;
        smp(); chk("m2_d0_grnt", 64'(b_lsu_grnt), 64'd1);
        nxt(); smp(); chk("m2_d1_grnt", 64'(b_lsu_grnt), 64'd1);
        nxt(); smp(); chk("m2_d2_grnt", 64'(b_lsu_grnt), 64'd0);
        nxt(); smp();
        chk("m2_d3_ostd", 64'(b_ostd), 64'd2);
        chk("m2_d3_grnt", 64'(b_lsu_grnt), 64'd0);
        nxt(); rd_done_b = 1'b1;
        smp(); chk("m2_d4_grnt", 64'(b_lsu_grnt), 64'd0);
        nxt(); rd_done_b = 1'b0;
        smp();
        chk("m2_d5_ostd", 64'(b_ostd), 64'd1);
        chk("m2_d5_grnt", 64'(b_lsu_grnt), 64'd1);
        nxt(); rd_done_b = 1'b1;
        smp();
        chk("m2_d6_arvalid", 64'(b_arvalid), 64'd1);
        chk("m2_d6_grnt",    64'(b_lsu_grnt), 64'd0);
        nxt(); rd_done_b = 1'b0;
        smp();
        chk("m2_d7_ostd", 64'(b_ostd), 64'd1);
        chk("m2_d7_grnt", 64'(b_lsu_grnt), 64'd1);

        // Drain with the model still checking.
        nxt(); lsu_ar_req = 1'b0; rd_done_a = 1'b1;
        for (int i = 0; i < 12; i++) nxt();
        smp();
        chk("final_ostd_a", 64'(a_ostd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
